// File: rtl/stl_arb_pkg.sv
// Shared types for the round-robin arbiter slice.
// Holds the two-state arbitration FSM encoding.
package stl_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/stl_rr_pick.sv
// Combinational rotating-priority encoder: first set bit of req at or after
// ptr, wrapping modulo NR_REQ. Rotation is done by slicing a doubled vector.
module stl_rr_pick #(
    parameter int NR_REQ = 4,
    parameter int IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic [NR_REQ-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              any,
    output logic [IDX_W-1:0]  idx,
    output logic [NR_REQ-1:0] oh
);

    logic [2*NR_REQ-1:0] dbl;
    logic [NR_REQ-1:0]   rot;
    logic [IDX_W:0]      off;
    logic [IDX_W:0]      sum;

    always_comb begin
        dbl = {req, req};
        rot = dbl[ptr +: NR_REQ];
        any = |req;

        // Scan high to low so the lowest set offset is the one left standing.
        off = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDX_W+1)'(i);
        end

        sum = {1'b0, ptr} + off;
        if (sum >= (IDX_W+1)'(NR_REQ)) sum = sum - (IDX_W+1)'(NR_REQ);
        idx = sum[IDX_W-1:0];

        oh = '0;
        if (any) oh = NR_REQ'(1) << idx;
    end

endmodule

// File: rtl/stl_rr_arb.sv
// Round-robin arbiter with valid/ready handshake and multi-beat lock.
// sel is frozen from the first beat of a transaction until its last handshake.
module stl_rr_arb
    import stl_arb_pkg::*;
#(
    parameter int NR_REQ = 4,
    parameter int IDX_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR_REQ-1:0] req_valid,
    input  logic [NR_REQ-1:0] req_last,
    output logic [NR_REQ-1:0] req_ready,
    output logic [IDX_W-1:0]  sel,
    output logic [NR_REQ-1:0] sel_oh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    arb_state_e        state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  lock_idx, lock_nxt;
    logic [IDX_W-1:0]  cur_idx, inc_idx;
    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [NR_REQ-1:0] pick_oh;
    logic              grant_vld;
    logic              grant_last;
    logic              hs;

    stl_rr_pick #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx),
        .oh  (pick_oh)
    );

    always_comb begin
        cur_idx    = (state == ARB_LOCK) ? lock_idx : pick_idx;
        grant_vld  = (state == ARB_LOCK) ? req_valid[cur_idx] : pick_any;
        grant_last = req_last[cur_idx];
        hs         = grant_vld & out_ready;
        inc_idx    = (cur_idx == IDX_W'(NR_REQ - 1)) ? '0 : cur_idx + IDX_W'(1);

        state_nxt = state;
        ptr_nxt   = ptr;
        lock_nxt  = lock_idx;
        case (state)
            ARB_IDLE: begin
                if (grant_vld) begin
                    if (hs && grant_last) begin
                        ptr_nxt = inc_idx;
                    end else begin
                        state_nxt = ARB_LOCK;
                        lock_nxt  = cur_idx;
                    end
                end
            end
            ARB_LOCK: begin
                if (hs && grant_last) begin
                    state_nxt = ARB_IDLE;
                    ptr_nxt   = inc_idx;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // While in reset every output is held low, even though the picker is live.
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        sel       = '0;
        sel_oh    = '0;
        req_ready = '0;
        if (!rst) begin
            out_valid = grant_vld;
            out_last  = grant_vld & grant_last;
            sel       = cur_idx;
            if (state == ARB_LOCK) begin
                if (grant_vld) sel_oh = NR_REQ'(1) << cur_idx;
                req_ready[cur_idx] = out_ready;
            end else begin
                sel_oh             = pick_oh;
                req_ready[cur_idx] = out_ready & grant_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lock_idx <= lock_nxt;
        end
    end

    // A raised request may only be withdrawn after it has been accepted.
    for (genvar g = 0; g < NR_REQ; g++) begin : g_hold
        a_req_hold: assert property (@(posedge clk) disable iff (rst)
            (req_valid[g] && !req_ready[g]) |=> req_valid[g]);
    end

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule

// File: tb/tb_stl_rr_arb.sv
// Directed bench for stl_rr_arb (NR_REQ=4): reset, rotation, backpressure,
// multi-beat lock, gaps inside a lock and reset in the middle of a lock.
module tb_stl_rr_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_last;
    logic [3:0] req_ready;
    logic [1:0] sel;
    logic [3:0] sel_oh;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    int vectors    = 0;
    int miscompares = 0;

    stl_rr_arb #(.NR_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .sel       (sel),
        .sel_oh    (sel_oh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Starts and ends on a negedge, leaving the DUT freshly reset and idle.
    task automatic apply_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if ({out_valid, out_last, sel, req_ready, sel_oh} !== 12'h000) begin
                miscompares++;
                $display("FAIL reset_hold_c%0d got ov=%b ol=%b sel=%0d rdy=%b oh=%b, want all zero",
                         c, out_valid, out_last, sel, req_ready, sel_oh);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready, sel_oh} !== {1'b1, 2'd0, 4'b0001, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_release got ov=%b sel=%0d rdy=%b oh=%b, want ov=1 sel=0 rdy=0001 oh=0001",
                     out_valid, sel, req_ready, sel_oh);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        req_valid = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            vectors++;
            if ({out_valid, out_last, sel, req_ready} !== {1'b1, 1'b1, exp_sel[c], exp_rdy[c]}) begin
                miscompares++;
                $display("FAIL rr_c%0d got ov=%b ol=%b sel=%0d rdy=%b, want ov=1 ol=1 sel=%0d rdy=%b",
                         c, out_valid, out_last, sel, req_ready, exp_sel[c], exp_rdy[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req_valid = 4'b0100; req_last = 4'b0100; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) req_valid = 4'b0101;
            #1;
            vectors++;
            if ({out_valid, sel, req_ready, sel_oh} !== {1'b1, 2'd2, 4'b0000, 4'b0100}) begin
                miscompares++;
                $display("FAIL bp_stall_c%0d got ov=%b sel=%0d rdy=%b oh=%b, want ov=1 sel=2 rdy=0000 oh=0100",
                         c, out_valid, sel, req_ready, sel_oh);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_last, sel, req_ready} !== {1'b1, 1'b1, 2'd2, 4'b0100}) begin
            miscompares++;
            $display("FAIL bp_release got ov=%b ol=%b sel=%0d rdy=%b, want ov=1 ol=1 sel=2 rdy=0100",
                     out_valid, out_last, sel, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0001; req_last = 4'b0001;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready} !== {1'b1, 2'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL bp_wrap got ov=%b sel=%0d rdy=%b, want ov=1 sel=0 rdy=0001",
                     out_valid, sel, req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_multi_beat();
        logic [3:0] beat_last [3] = '{4'b1001, 4'b1001, 4'b1011};
        apply_reset();
        // Single beat on 0 moves ptr to 1 so requester 1 wins next.
        req_valid = 4'b0001; req_last = 4'b0001; out_ready = 1'b1;
        #1;
        vectors++;
        if ({sel, req_ready} !== {2'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL mb_prime got sel=%0d rdy=%b, want sel=0 rdy=0001", sel, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1011;
        for (int b = 0; b < 3; b++) begin
            req_last = beat_last[b];
            #1;
            vectors++;
            if ({out_valid, out_last, sel, req_ready} !== {1'b1, (b == 2), 2'd1, 4'b0010}) begin
                miscompares++;
                $display("FAIL mb_beat%0d got ov=%b ol=%b sel=%0d rdy=%b, want ov=1 ol=%0d sel=1 rdy=0010",
                         b, out_valid, out_last, sel, req_ready, (b == 2));
            end
            @(negedge clk);
        end
        req_valid = 4'b1001; req_last = 4'b1001;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready, sel_oh} !== {1'b1, 2'd3, 4'b1000, 4'b1000}) begin
            miscompares++;
            $display("FAIL mb_next got ov=%b sel=%0d rdy=%b oh=%b, want ov=1 sel=3 rdy=1000 oh=1000",
                     out_valid, sel, req_ready, sel_oh);
        end
        @(negedge clk);
    endtask

    task automatic test_lock_gap();
        apply_reset();
        req_valid = 4'b1010; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready} !== {1'b1, 2'd1, 4'b0010}) begin
            miscompares++;
            $display("FAIL gap_beat1 got ov=%b sel=%0d rdy=%b, want ov=1 sel=1 rdy=0010",
                     out_valid, sel, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        vectors++;
        if ({out_valid, sel, sel_oh, (req_ready & 4'b1101)} !== {1'b0, 2'd1, 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("FAIL gap_hole got ov=%b sel=%0d oh=%b rdy=%b, want ov=0 sel=1 oh=0000 rdy[3,2,0]=0",
                     out_valid, sel, sel_oh, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1010; req_last = 4'b0010;
        #1;
        vectors++;
        if ({out_valid, out_last, sel, req_ready} !== {1'b1, 1'b1, 2'd1, 4'b0010}) begin
            miscompares++;
            $display("FAIL gap_beat2 got ov=%b ol=%b sel=%0d rdy=%b, want ov=1 ol=1 sel=1 rdy=0010",
                     out_valid, out_last, sel, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1000; req_last = 4'b1000;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready} !== {1'b1, 2'd3, 4'b1000}) begin
            miscompares++;
            $display("FAIL gap_after got ov=%b sel=%0d rdy=%b, want ov=1 sel=3 rdy=1000",
                     out_valid, sel, req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready} !== {1'b1, 2'd2, 4'b0100}) begin
            miscompares++;
            $display("FAIL rml_beat1 got ov=%b sel=%0d rdy=%b, want ov=1 sel=2 rdy=0100",
                     out_valid, sel, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0101; rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_last, sel, req_ready, sel_oh} !== 12'h000) begin
            miscompares++;
            $display("FAIL rml_in_reset got ov=%b ol=%b sel=%0d rdy=%b oh=%b, want all zero",
                     out_valid, out_last, sel, req_ready, sel_oh);
        end
        @(negedge clk);
        rst = 1'b0; req_last = 4'b0101;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready} !== {1'b1, 2'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL rml_after got ov=%b sel=%0d rdy=%b, want ov=1 sel=0 rdy=0001",
                     out_valid, sel, req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        vectors++;
        if ({out_valid, sel, req_ready} !== {1'b1, 2'd2, 4'b0100}) begin
            miscompares++;
            $display("FAIL rml_next got ov=%b sel=%0d rdy=%b, want ov=1 sel=2 rdy=0100",
                     out_valid, sel, req_ready);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_multi_beat();
        test_lock_gap();
        test_reset_mid_lock();
        apply_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
